// File: rtl/soft_rst_if.sv
// Request/status bundle between the soft-reset controller and its surroundings.
// The slave side is the controller; the master side drives the request sources.
interface soft_rst_if #(
  parameter int unsigned WDT_W = 32
);
  logic             sw_req_i;
  logic             dbg_req_i;
  logic             wdt_en_i;
  logic             wdt_kick_i;
  logic [WDT_W-1:0] wdt_load_i;
  logic             c_rstn_i;
  logic             cause_clr_i;
  logic             soft_reset_en_o;
  logic             busy_o;
  logic [2:0]       cause_o;
  logic [WDT_W-1:0] wdt_count_o;

  modport slave (
    input  sw_req_i, dbg_req_i, wdt_en_i, wdt_kick_i, wdt_load_i, c_rstn_i, cause_clr_i,
    output soft_reset_en_o, busy_o, cause_o, wdt_count_o
  );

  modport master (
    output sw_req_i, dbg_req_i, wdt_en_i, wdt_kick_i, wdt_load_i, c_rstn_i, cause_clr_i,
    input  soft_reset_en_o, busy_o, cause_o, wdt_count_o
  );
endinterface

// File: rtl/soft_rst_ctrl.sv
// Soft-reset request controller: merges sw, debug and watchdog requests into one
// stretched soft_reset_en pulse, waits for core reset release, keeps a sticky cause.
module soft_rst_ctrl #(
  parameter int unsigned PULSE_CYCLES = 8,
  parameter int unsigned WDT_W        = 32
) (
  input logic       clk_i,
  input logic       rst_ni,
  soft_rst_if.slave bus
);

  localparam int unsigned PCNT_W = 8;
  localparam logic [PCNT_W-1:0] PULSE_LOAD = PCNT_W'(PULSE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic              pending_q, pending_d;
  logic              dbg_q, dbg_d;
  logic              dbg_armed_q, dbg_armed_d;
  logic              wdt_en_q, wdt_en_d;
  logic [WDT_W-1:0]  wdt_cnt_q, wdt_cnt_d;
  logic [2:0]        cause_q, cause_d;
  logic              soft_reset_en_q, soft_reset_en_d;
  logic              busy_q, busy_d;

  logic req_sw, req_dbg, req_wdt, any_req;

  // Debug edge detect; the armed flag suppresses a level already high at reset release.
  always_comb begin
    req_sw      = bus.sw_req_i;
    req_dbg     = bus.dbg_req_i & ~dbg_q & dbg_armed_q;
    dbg_d       = bus.dbg_req_i;
    dbg_armed_d = 1'b1;
    wdt_en_d    = bus.wdt_en_i;
  end

  // Watchdog: reload on enable edge or kick, park at the load value outside IDLE.
  always_comb begin
    wdt_cnt_d = wdt_cnt_q;
    req_wdt   = 1'b0;
    if (bus.wdt_en_i) begin
      if (!wdt_en_q || bus.wdt_kick_i) begin
        wdt_cnt_d = bus.wdt_load_i;
      end else if (state_q != ST_IDLE) begin
        wdt_cnt_d = bus.wdt_load_i;
      end else if (wdt_cnt_q != '0) begin
        wdt_cnt_d = wdt_cnt_q - WDT_W'(1);
        req_wdt   = (wdt_cnt_q == WDT_W'(1));
      end
    end
  end

  // Pulse FSM; requests arriving while busy are folded into a single pending rerun.
  always_comb begin
    any_req   = req_sw | req_dbg | req_wdt;
    state_d   = state_q;
    pcnt_d    = pcnt_q;
    pending_d = pending_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_ASSERT;
          pcnt_d  = PULSE_LOAD;
        end
      end
      ST_ASSERT: begin
        if (any_req) pending_d = 1'b1;
        if (pcnt_q != '0) begin
          pcnt_d = pcnt_q - PCNT_W'(1);
        end else if (!bus.dbg_req_i) begin
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (bus.c_rstn_i) begin
          if (pending_q || any_req) begin
            state_d   = ST_ASSERT;
            pcnt_d    = PULSE_LOAD;
            pending_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (any_req) begin
          pending_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cause_d         = {req_wdt, req_dbg, req_sw} | (cause_q & {3{~bus.cause_clr_i}});
    soft_reset_en_d = (state_d == ST_ASSERT);
    busy_d          = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= ST_IDLE;
      pcnt_q          <= '0;
      pending_q       <= 1'b0;
      dbg_q           <= 1'b0;
      dbg_armed_q     <= 1'b0;
      wdt_en_q        <= 1'b0;
      wdt_cnt_q       <= '0;
      cause_q         <= '0;
      soft_reset_en_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      pcnt_q          <= pcnt_d;
      pending_q       <= pending_d;
      dbg_q           <= dbg_d;
      dbg_armed_q     <= dbg_armed_d;
      wdt_en_q        <= wdt_en_d;
      wdt_cnt_q       <= wdt_cnt_d;
      cause_q         <= cause_d;
      soft_reset_en_q <= soft_reset_en_d;
      busy_q          <= busy_d;
    end
  end

  assign bus.soft_reset_en_o = soft_reset_en_q;
  assign bus.busy_o          = busy_q;
  assign bus.cause_o         = cause_q;
  assign bus.wdt_count_o     = wdt_cnt_q;

endmodule

// File: tb/tb_soft_rst_ctrl.sv
// Directed self-checking bench for soft_rst_ctrl (PULSE_CYCLES=8, WDT_W=32).
module tb_soft_rst_ctrl;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  soft_rst_if #(.WDT_W(32)) bus ();

  soft_rst_ctrl #(.PULSE_CYCLES(8), .WDT_W(32)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic measure_pulse(output int n);
    n = 0;
    for (int i = 0; i < 60; i++) begin
      if (bus.soft_reset_en_o !== 1'b1) break;
      n++;
      tick();
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 100; i++) begin
      if (bus.busy_o === 1'b0) break;
      tick();
    end
    chk(tag, 32'(bus.busy_o), 32'd0);
  endtask

  int   hi;
  logic seen;

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.sw_req_i    = 1'b0;
    bus.dbg_req_i   = 1'b0;
    bus.wdt_en_i    = 1'b0;
    bus.wdt_kick_i  = 1'b0;
    bus.wdt_load_i  = '0;
    bus.c_rstn_i    = 1'b1;
    bus.cause_clr_i = 1'b0;

    // Reset state
    repeat (3) tick();
    chk("rst_en",    32'(bus.soft_reset_en_o), 32'd0);
    chk("rst_busy",  32'(bus.busy_o),          32'd0);
    chk("rst_cause", 32'(bus.cause_o),         32'd0);
    chk("rst_wdt",   bus.wdt_count_o,          32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) tick();

    // Software request: 8-cycle pulse, then wait for core reset release
    bus.sw_req_i = 1'b1;
    tick();
    bus.sw_req_i = 1'b0;
    bus.c_rstn_i = 1'b0;
    chk("sw_en_next",  32'(bus.soft_reset_en_o), 32'd1);
    chk("sw_busy",     32'(bus.busy_o),          32'd1);
    chk("sw_cause",    32'(bus.cause_o),         32'd1);
    measure_pulse(hi);
    chk("sw_width",    32'(hi),                  32'd8);
    repeat (3) tick();
    chk("sw_rel_busy", 32'(bus.busy_o),          32'd1);
    chk("sw_rel_en",   32'(bus.soft_reset_en_o), 32'd0);
    bus.c_rstn_i = 1'b1;
    tick();
    chk("sw_idle",     32'(bus.busy_o),          32'd0);
    chk("sw_cause_st", 32'(bus.cause_o),         32'd1);
    bus.cause_clr_i = 1'b1;
    tick();
    bus.cause_clr_i = 1'b0;
    chk("cause_clr",   32'(bus.cause_o),         32'd0);

    // Debug request held past the pulse length
    bus.dbg_req_i = 1'b1;
    tick();
    chk("dbg_en",      32'(bus.soft_reset_en_o), 32'd1);
    chk("dbg_cause",   32'(bus.cause_o),         32'd2);
    repeat (24) tick();
    chk("dbg_hold",    32'(bus.soft_reset_en_o), 32'd1);
    bus.dbg_req_i = 1'b0;
    tick();
    chk("dbg_release", 32'(bus.soft_reset_en_o), 32'd0);
    tick();
    chk("dbg_idle",    32'(bus.busy_o),          32'd0);
    bus.cause_clr_i = 1'b1;
    tick();
    bus.cause_clr_i = 1'b0;

    // Watchdog expiry: load 20, enable in cycle 0, pulse from cycle 21
    bus.wdt_load_i = 32'd20;
    bus.wdt_en_i   = 1'b1;
    repeat (20) tick();
    chk("wdt_pre_en",  32'(bus.soft_reset_en_o), 32'd0);
    chk("wdt_pre_cnt", bus.wdt_count_o,          32'd1);
    tick();
    chk("wdt_exp_en",  32'(bus.soft_reset_en_o), 32'd1);
    chk("wdt_cause",   32'(bus.cause_o),         32'd4);
    chk("wdt_zero",    bus.wdt_count_o,          32'd0);
    tick();
    chk("wdt_park",    bus.wdt_count_o,          32'd20);
    bus.wdt_en_i = 1'b0;
    wait_idle("wdt_idle");
    bus.cause_clr_i = 1'b1;
    tick();
    bus.cause_clr_i = 1'b0;

    // Kicked every 10 cycles for 200 cycles: never expires
    bus.wdt_en_i = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      bus.wdt_kick_i = 1'b1;
      tick();
      seen = seen | bus.soft_reset_en_o;
      bus.wdt_kick_i = 1'b0;
      repeat (9) begin
        tick();
        seen = seen | bus.soft_reset_en_o;
      end
    end
    chk("kick_no_exp", 32'(seen),              32'd0);
    chk("kick_cnt",    bus.wdt_count_o,        32'd11);
    chk("kick_cause",  32'(bus.cause_o),       32'd0);
    bus.wdt_en_i = 1'b0;
    repeat (5) tick();
    chk("wdt_frozen",  bus.wdt_count_o,        32'd11);

    // Kick on the 1->0 cycle wins over expiry
    bus.wdt_load_i = 32'd3;
    bus.wdt_en_i   = 1'b1;
    repeat (3) tick();
    chk("kw_cnt1",     bus.wdt_count_o,        32'd1);
    bus.wdt_kick_i = 1'b1;
    tick();
    bus.wdt_kick_i = 1'b0;
    bus.wdt_en_i   = 1'b0;
    chk("kick_wins",   32'(bus.soft_reset_en_o), 32'd0);
    chk("kw_reload",   bus.wdt_count_o,        32'd3);

    // Zero load value never expires
    bus.wdt_load_i = 32'd0;
    tick();
    bus.wdt_en_i = 1'b1;
    repeat (10) tick();
    chk("load0_cnt",   bus.wdt_count_o,        32'd0);
    chk("load0_busy",  32'(bus.busy_o),        32'd0);
    bus.wdt_en_i = 1'b0;
    tick();

    // Request during ASSERT becomes pending; rerun right after RELEASE
    bus.sw_req_i = 1'b1;
    tick();
    bus.sw_req_i = 1'b0;
    bus.c_rstn_i = 1'b0;
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.soft_reset_en_o !== 1'b1) break;
      hi++;
      bus.sw_req_i = (i == 2);
      tick();
    end
    bus.sw_req_i = 1'b0;
    chk("pend_width1", 32'(hi),                32'd8);
    chk("pend_rel",    32'(bus.busy_o),        32'd1);
    tick();
    chk("pend_wait",   32'(bus.soft_reset_en_o), 32'd0);
    bus.c_rstn_i = 1'b1;
    tick();
    chk("pend_rerun",  32'(bus.soft_reset_en_o), 32'd1);
    measure_pulse(hi);
    chk("pend_width2", 32'(hi),                32'd8);
    tick();
    chk("pend_done",   32'(bus.busy_o),        32'd0);
    bus.cause_clr_i = 1'b1;
    tick();
    bus.cause_clr_i = 1'b0;

    // Clear coincident with sw request while cause is 3'b110
    bus.dbg_req_i = 1'b1;
    tick();
    bus.dbg_req_i = 1'b0;
    wait_idle("c110_dbg_idle");
    bus.wdt_load_i = 32'd2;
    bus.wdt_en_i   = 1'b1;
    repeat (3) tick();
    chk("c110_en",     32'(bus.soft_reset_en_o), 32'd1);
    chk("c110_cause",  32'(bus.cause_o),       32'd6);
    bus.sw_req_i    = 1'b1;
    bus.cause_clr_i = 1'b1;
    bus.wdt_en_i    = 1'b0;
    tick();
    bus.sw_req_i    = 1'b0;
    bus.cause_clr_i = 1'b0;
    chk("clr_set_win", 32'(bus.cause_o),       32'd1);
    wait_idle("c110_idle");

    // Async reset mid-ASSERT; debug already high at release must not trigger
    bus.sw_req_i = 1'b1;
    tick();
    bus.sw_req_i = 1'b0;
    tick();
    chk("ar_pre_en",   32'(bus.soft_reset_en_o), 32'd1);
    #2;
    rst_n = 1'b0;
    bus.dbg_req_i = 1'b1;
    #1;
    chk("ar_en",       32'(bus.soft_reset_en_o), 32'd0);
    chk("ar_cause",    32'(bus.cause_o),       32'd0);
    chk("ar_busy",     32'(bus.busy_o),        32'd0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      tick();
      seen = seen | bus.soft_reset_en_o | bus.busy_o;
    end
    chk("ar_no_req",   32'(seen),              32'd0);
    chk("ar_cause2",   32'(bus.cause_o),       32'd0);
    bus.dbg_req_i = 1'b0;
    tick();
    bus.dbg_req_i = 1'b1;
    tick();
    chk("ar_dbg_edge", 32'(bus.soft_reset_en_o), 32'd1);
    chk("ar_dbg_cause",32'(bus.cause_o),       32'd2);
    bus.dbg_req_i = 1'b0;
    wait_idle("ar_final_idle");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
